// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory, with bounded locked bursts and read-response routing.
// Optional macro DMEM_ARB_RR_EN: round-robin priority in ARB (fixed M0 priority when undefined).
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic          r_rvalid, r_rsel;
  logic          w_pick1;
  logic          w_gnt0_raw, w_gnt1_raw;
  logic          w_gnt0, w_gnt1;
  logic          w_rd_issue;

`ifdef DMEM_ARB_RR_EN
  logic          r_last, w_last_nxt;
`endif

  // Next-state and grant decision
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_pick1        = 1'b0;
    w_gnt0_raw     = 1'b0;
    w_gnt1_raw     = 1'b0;
`ifdef DMEM_ARB_RR_EN
    w_last_nxt     = r_last;
`endif
    case (r_state)
      ARB: begin
        if (req0 || req1) begin
`ifdef DMEM_ARB_RR_EN
          w_pick1    = req1 && (!req0 || !r_last);
          w_last_nxt = w_pick1;
`else
          w_pick1    = !req0;
`endif
          w_gnt0_raw = !w_pick1;
          w_gnt1_raw = w_pick1;
          if ((MAX_LOCK > 1) && (w_pick1 ? lock1 : lock0)) begin
            w_state_nxt    = w_pick1 ? LOCK1 : LOCK0;
            w_beat_cnt_nxt = CW'(1);
          end
        end
      end
      LOCK0: begin
        if (req0) begin
          w_gnt0_raw = 1'b1;
          if (!lock0 || (r_beat_cnt + CW'(1) == CW'(MAX_LOCK))) begin
            w_state_nxt    = ARB;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end else begin
          w_state_nxt    = ARB;
          w_beat_cnt_nxt = '0;
        end
      end
      LOCK1: begin
        if (req1) begin
          w_gnt1_raw = 1'b1;
          if (!lock1 || (r_beat_cnt + CW'(1) == CW'(MAX_LOCK))) begin
            w_state_nxt    = ARB;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end else begin
          w_state_nxt    = ARB;
          w_beat_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ARB;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // Grants are suppressed combinationally while reset is held
  assign w_gnt0     = w_gnt0_raw & rst;
  assign w_gnt1     = w_gnt1_raw & rst;
  assign w_rd_issue = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_en    = w_gnt0 | w_gnt1;
  assign mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign mem_addr  = w_gnt1 ? addr1 : addr0;
  assign mem_wdata = w_gnt1 ? wdata1 : wdata0;

  assign rvalid0 = r_rvalid & ~r_rsel;
  assign rvalid1 = r_rvalid & r_rsel;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  // State, burst counter and read-owner tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rsel     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rvalid   <= w_rd_issue;
      if (w_rd_issue) begin
        r_rsel <= w_gnt1;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last winner; reset to M1 so M0 is favoured first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else begin
      r_last <= w_last_nxt;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two masters: M0, the CPU data-port adapter, and M1, the program loader / debug access port.
- Arbitrates every cycle and supports locked bursts with a bounded length.
- Routes read responses back to the master that issued the read.
- Sits between the masters and DMem. Memory read latency is fixed at 1 cycle.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_LOCK, 8, maximum beats one master may hold in a locked burst (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
req0  in  1  M0 access request, held until granted
we0  in  1  M0 write enable (1=write, 0=read)
lock0  in  1  M0 requests burst lock
addr0  in  AW  M0 byte address
wdata0  in  DW  M0 write data
gnt0  out  1  M0 beat accepted this cycle
rvalid0  out  1  M0 read data valid
rdata0  out  DW  M0 read data
req1/we1/lock1/addr1/wdata1  in  1/1/1/AW/DW  M1 request, same semantics as M0
gnt1/rvalid1/rdata1  out  1/1/DW  M1 response, same semantics as M0
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after a read strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - State=ARB, last=M1 (so M0 has priority first), beat_cnt=0, rvalid0/1=0, rsel=0.
  - While reset is asserted, gnt0/1, mem_en and mem_we are forced to 0.
  - mem_addr and mem_wdata are don't-care during reset.
- Grant and command path:
  - A grant is combinational in the cycle it is given.
  - In a granted cycle: mem_en=1; mem_we, mem_addr and mem_wdata come from the granted master.
  - In a cycle with no grant: mem_en=0, mem_we=0.
  - At most one of gnt0/gnt1 is high in any cycle.
- FSM states: ARB, LOCK0, LOCK1.
- ARB:
  - Winner among the asserted reqs is chosen by the priority rule; the winner's gnt=1 and `last` is updated to the winner.
  - If the winner's lock=1 and MAX_LOCK>1: next state LOCKx, beat_cnt=1.
  - Otherwise stay in ARB.
  - No req asserted: no grant, stay in ARB.
- LOCKx:
  - Only master x can be granted; the other master waits.
  - req_x=1: gnt_x=1 and beat_cnt increments.
    - Return to ARB after this beat if lock_x=0 or beat_cnt+1==MAX_LOCK; this beat is still granted.
  - req_x=0: no grant this cycle (bubble), next state ARB, beat_cnt=0.
- Read return:
  - A granted read (we=0) sets rvalid_x=1 on the next cycle for exactly one cycle. rsel records the owner of the read.
  - rdata0 and rdata1 both equal mem_rdata; only the rvalid of the issuing master qualifies it.
  - Writes never produce rvalid.
  - Back-to-back reads from alternating masters give back-to-back rvalids with the correct owner each cycle.
- Reset mid-burst:
  - The burst is abandoned.
  - Any pending rvalid is cleared.
  - No grant is issued until rst is released.
- Masters must hold req/we/addr/wdata stable until gnt. The arbiter does not register request payloads.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin priority in ARB. When both masters request, the master not equal to `last` wins.
- Undefined: fixed priority in ARB; M0 always wins when both request. The `last` register is not used.
- Lock behaviour is identical in both builds.

Test Plan:
1. Assert rst=0 during a LOCK1 burst with a read outstanding. Required response:
   - gnt0/1, mem_en and rvalid0/1 go to 0 immediately, before the next clock edge.
   - After release, the first grant with both masters requesting goes to M0.
2. M0 reads addr 0x10, with memory holding 0x12345678 there. Required response:
   - Same cycle: gnt0=1, mem_en=1, mem_we=0, mem_addr=0x10.
   - Next cycle: rvalid0=1, rdata0=0x12345678, rvalid1=0.
3. M1 writes addr 0x20, data 0xDEADBEEF, then M0 reads 0x20. Required response:
   - Write cycle: mem_we=1, mem_wdata=0xDEADBEEF, and no rvalid follows.
   - Then rvalid0=1 with rdata0=0xDEADBEEF.
4. req0 and req1 held high with lock=0 for 6 cycles. Required response:
   - With DMEM_ARB_RR_EN defined: grants 0,1,0,1,0,1.
   - Without it: gnt0 is 1 for all 6 cycles.
5. MAX_LOCK=4; M1 holds lock1=1 and req1=1 while req0=1 throughout. Required response:
   - Exactly 4 consecutive gnt1 cycles, then gnt0=1 on the 5th cycle.
6. M1 locked burst where req1 drops after 2 beats, with req0=1. Required response:
   - gnt1 for 2 cycles, then one bubble cycle (mem_en=0), then gnt0=1.
